// File: rtl/io_pins_readback_pkg.sv
// Shared register map and field layout for the GPIO readback block.
package io_pins_readback_pkg;

   // Register addresses on the serial register bus
   localparam logic [6:0] FR_RB_EDGE_EN_0 = 7'h10;
   localparam logic [6:0] FR_RB_EDGE_EN_1 = 7'h11;
   localparam logic [6:0] FR_RB_CHG_CLR   = 7'h12;
   localparam logic [6:0] FR_RB_IRQ_MASK  = 7'h13;
   localparam logic [6:0] FR_RB_SNAP      = 7'h14;

   // Field layout
   localparam int          BANK_W    = 16;
   localparam int          BANK1_LSB = 16;
   localparam logic [15:0] EVT_SAT   = 16'hFFFF;

   // Per-bank control decoded from one register write
   typedef struct packed {
      logic              en_we;    // edge-enable mask write
      logic [BANK_W-1:0] en_mask;  // bits of edge_en to update
      logic [BANK_W-1:0] en_val;   // new values for masked bits
      logic [BANK_W-1:0] clr;      // write-1-to-clear sticky flags
   } bank_ctrl_t;

   // Saturating event-counter step
   function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
      return (inc && (c != EVT_SAT)) ? c + 16'd1 : c;
   endfunction

endpackage

// File: rtl/pin_edge_capture.sv
// One GPIO bank: pad synchroniser, edge detect and sticky change flags.
module pin_edge_capture
   import io_pins_readback_pkg::*;
#(
   parameter int SYNC_STAGES = 2   // legal 2..4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [BANK_W-1:0] pin_in,
   input  logic              armed,
   input  bank_ctrl_t        ctrl,
   output logic [BANK_W-1:0] sync,
   output logic [BANK_W-1:0] evt,
   output logic [BANK_W-1:0] chg
);

   logic [SYNC_STAGES-1:0][BANK_W-1:0] sync_q;
   logic [BANK_W-1:0]                  prev;
   logic [BANK_W-1:0]                  edge_en;

   assign sync = sync_q[SYNC_STAGES-1];

   // Edges only count once the synchroniser has flushed after reset
   assign evt = armed ? ((sync ^ prev) & edge_en) : '0;

   // Synchroniser shift chain; pad enters at stage 0
   always_ff @(posedge clock) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
   end

   // prev follows sync even while disarmed so reset-time levels are absorbed
   always_ff @(posedge clock) begin
      if (reset) prev <= '0;
      else       prev <= sync;
   end

   // Masked update of the edge enables: only bits selected by en_mask change
   always_ff @(posedge clock) begin
      if (reset)           edge_en <= '0;
      else if (ctrl.en_we) edge_en <= (edge_en & ~ctrl.en_mask) | (ctrl.en_val & ctrl.en_mask);
   end

   // Sticky flags; a new event beats a same-cycle clear
   always_ff @(posedge clock) begin
      if (reset) chg <= '0;
      else       chg <= (chg & ~ctrl.clr) | evt;
   end

endmodule

// File: rtl/io_pins_readback.sv
// GPIO readback top: register decode, arming window, IRQ, event counter, snapshot.
module io_pins_readback
   import io_pins_readback_pkg::*;
#(
   parameter int         SYNC_STAGES    = 2,
   parameter logic [6:0] ADDR_EDGE_EN_0 = FR_RB_EDGE_EN_0,
   parameter logic [6:0] ADDR_EDGE_EN_1 = FR_RB_EDGE_EN_1,
   parameter logic [6:0] ADDR_CHG_CLR   = FR_RB_CHG_CLR,
   parameter logic [6:0] ADDR_IRQ_MASK  = FR_RB_IRQ_MASK,
   parameter logic [6:0] ADDR_SNAP      = FR_RB_SNAP
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] io_0_in,
   input  logic [15:0] io_1_in,
   input  logic [6:0]  serial_addr,
   input  logic [31:0] serial_data,
   input  logic        serial_strobe,
   output logic [31:0] readback_io,
   output logic [31:0] readback_chg,
   output logic [31:0] readback_snap,
   output logic [31:0] readback_evt,
   output logic        change_irq
);

   localparam int ARM_CYC = SYNC_STAGES + 1;

   bank_ctrl_t        ctrl_0, ctrl_1;
   logic              irq_we, snap_we;
   logic [BANK_W-1:0] sync_0, sync_1, evt_0, evt_1, chg_0, chg_1;
   logic [31:0]       irq_mask;
   logic [2:0]        arm_cnt;
   logic              armed;
   logic              any_evt;
   logic [15:0]       evt_cnt, cnt_next;

   assign armed    = (arm_cnt == 3'(ARM_CYC));
   assign any_evt  = |{evt_1, evt_0};
   assign cnt_next = sat_inc(evt_cnt, any_evt);

   assign readback_chg = {chg_1, chg_0};

   // Register write decode; unknown addresses fall through to no-op
   always_comb begin
      ctrl_0  = '0;
      ctrl_1  = '0;
      irq_we  = 1'b0;
      snap_we = 1'b0;
      if (serial_strobe) begin
         case (serial_addr)
            ADDR_EDGE_EN_0: begin
               ctrl_0.en_we   = 1'b1;
               ctrl_0.en_mask = serial_data[BANK1_LSB +: BANK_W];
               ctrl_0.en_val  = serial_data[BANK_W-1:0];
            end
            ADDR_EDGE_EN_1: begin
               ctrl_1.en_we   = 1'b1;
               ctrl_1.en_mask = serial_data[BANK1_LSB +: BANK_W];
               ctrl_1.en_val  = serial_data[BANK_W-1:0];
            end
            ADDR_CHG_CLR: begin
               ctrl_0.clr = serial_data[BANK_W-1:0];
               ctrl_1.clr = serial_data[BANK1_LSB +: BANK_W];
            end
            ADDR_IRQ_MASK: irq_we  = 1'b1;
            ADDR_SNAP:     snap_we = 1'b1;
            default: ;
         endcase
      end
   end

   pin_edge_capture #(.SYNC_STAGES(SYNC_STAGES)) u_bank_0 (
      .clock(clock), .reset(reset), .pin_in(io_0_in), .armed(armed),
      .ctrl(ctrl_0), .sync(sync_0), .evt(evt_0), .chg(chg_0)
   );

   pin_edge_capture #(.SYNC_STAGES(SYNC_STAGES)) u_bank_1 (
      .clock(clock), .reset(reset), .pin_in(io_1_in), .armed(armed),
      .ctrl(ctrl_1), .sync(sync_1), .evt(evt_1), .chg(chg_1)
   );

   // Arming window: count up after reset until the synchroniser has flushed
   always_ff @(posedge clock) begin
      if (reset)       arm_cnt <= '0;
      else if (!armed) arm_cnt <= arm_cnt + 3'd1;
   end

   // IRQ mask register
   always_ff @(posedge clock) begin
      if (reset)       irq_mask <= '0;
      else if (irq_we) irq_mask <= serial_data;
   end

   // Live readback and registered level interrupt
   always_ff @(posedge clock) begin
      if (reset) begin
         readback_io <= '0;
         change_irq  <= 1'b0;
      end else begin
         readback_io <= {sync_1, sync_0};
         change_irq  <= |({chg_1, chg_0} & irq_mask);
      end
   end

   // Event counter and snapshot; a snapshot includes this cycle's event and
   // the counter restarts counting that same event
   always_ff @(posedge clock) begin
      if (reset) begin
         evt_cnt       <= '0;
         readback_snap <= '0;
         readback_evt  <= '0;
      end else if (snap_we) begin
         evt_cnt       <= {15'h0, any_evt};
         readback_snap <= {sync_1, sync_0};
         readback_evt  <= {16'h0, cnt_next};
      end else begin
         evt_cnt       <= cnt_next;
      end
   end

endmodule

// File: tb/tb_io_pins_readback.sv
// Scenario bench for io_pins_readback with an expected-value queue.
module tb_io_pins_readback;
   import io_pins_readback_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] io_0_in = '0, io_1_in = '0;
   logic [6:0]  serial_addr = '0;
   logic [31:0] serial_data = '0;
   logic        serial_strobe = 1'b0;
   logic [31:0] readback_io, readback_chg, readback_snap, readback_evt;
   logic        change_irq;

   int total = 0;
   int bad   = 0;

   typedef struct { string name; logic [31:0] exp; } sb_t;
   sb_t sb[$];
   sb_t e;
   logic [31:0] obs[5];

   io_pins_readback #(.SYNC_STAGES(2)) dut (
      .clock(clock), .reset(reset), .io_0_in(io_0_in), .io_1_in(io_1_in),
      .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
      .readback_io(readback_io), .readback_chg(readback_chg), .readback_snap(readback_snap),
      .readback_evt(readback_evt), .change_irq(change_irq)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      serial_addr = a; serial_data = d; serial_strobe = 1'b1;
      tick(1);
      serial_strobe = 1'b0; serial_addr = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1; io_0_in = 16'hFFFF; io_1_in = '0;
      tick(2);
      sb.push_back('{name:"rst_io",   exp:32'h0});
      sb.push_back('{name:"rst_chg",  exp:32'h0});
      sb.push_back('{name:"rst_snap", exp:32'h0});
      sb.push_back('{name:"rst_evt",  exp:32'h0});
      sb.push_back('{name:"rst_irq",  exp:32'h0});
      obs = '{readback_io, readback_chg, readback_snap, readback_evt, {31'h0, change_irq}};
      for (int i = 0; i < 5; i++) begin
         e = sb.pop_front(); total++;
         if (obs[i] !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs[i], e.exp); end
      end
      reset = 1'b0;
      sb.push_back('{name:"io_sync_latency", exp:32'h0000FFFF});
      tick(3);
      e = sb.pop_front(); total++;
      if (readback_io !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_io, e.exp); end
      for (int i = 0; i < 17; i++) begin
         sb.push_back('{name:"quiet_chg", exp:32'h0});
         sb.push_back('{name:"quiet_irq", exp:32'h0});
         tick(1);
         e = sb.pop_front(); total++;
         if (readback_chg !== e.exp) begin bad++; $display("FAIL %s cyc=%0d got=%h want=%h", e.name, i, readback_chg, e.exp); end
         e = sb.pop_front(); total++;
         if ({31'h0, change_irq} !== e.exp) begin bad++; $display("FAIL %s cyc=%0d got=%b want=%h", e.name, i, change_irq, e.exp); end
      end
   endtask

   task automatic test_edge_irq;
      io_0_in = '0;
      tick(4);
      wr(FR_RB_EDGE_EN_0, 32'h0001_0001);
      wr(FR_RB_IRQ_MASK, 32'h1);
      io_0_in[0] = 1'b1;                 // sampled at edge k
      sb.push_back('{name:"chg_k1", exp:32'h0});
      tick(2);
      e = sb.pop_front(); total++;
      if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
      sb.push_back('{name:"chg_k2", exp:32'h1});
      sb.push_back('{name:"irq_k2", exp:32'h0});
      tick(1);
      e = sb.pop_front(); total++;
      if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
      e = sb.pop_front(); total++;
      if ({31'h0, change_irq} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%h", e.name, change_irq, e.exp); end
      sb.push_back('{name:"irq_k3", exp:32'h1});
      tick(1);
      e = sb.pop_front(); total++;
      if ({31'h0, change_irq} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%h", e.name, change_irq, e.exp); end
      sb.push_back('{name:"clr_chg", exp:32'h0});
      wr(FR_RB_CHG_CLR, 32'h1);
      e = sb.pop_front(); total++;
      if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
      sb.push_back('{name:"clr_irq", exp:32'h0});
      tick(1);
      e = sb.pop_front(); total++;
      if ({31'h0, change_irq} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%h", e.name, change_irq, e.exp); end
   endtask

   task automatic test_mask_write;
      logic [3:0]  pins[4];
      logic [31:0] exps[4];
      pins = '{4'd4, 4'd5, 4'd0, 4'd7};
      // edge_en_1 = 0x00AF after the mask write
      exps = '{32'h0000_0000, 32'h0020_0000, 32'h0021_0000, 32'h00A1_0000};
      wr(FR_RB_EDGE_EN_1, 32'hFFFF_000F);
      wr(FR_RB_EDGE_EN_1, 32'h00F0_00A0);
      for (int i = 0; i < 4; i++) begin
         io_1_in[pins[i]] = 1'b1;
         sb.push_back('{name:$sformatf("mask_pin%0d", pins[i]), exp:exps[i]});
         tick(4);
         e = sb.pop_front(); total++;
         if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
      end
      sb.push_back('{name:"mask_clr", exp:32'h0});
      wr(FR_RB_CHG_CLR, 32'hFFFF_0000);
      e = sb.pop_front(); total++;
      if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
   endtask

   task automatic test_set_wins;
      wr(FR_RB_EDGE_EN_0, 32'h0008_0008);
      io_0_in[3] = 1'b1;
      sb.push_back('{name:"pin3_set", exp:32'h0000_0008});
      tick(4);
      e = sb.pop_front(); total++;
      if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
      io_0_in[3] = 1'b0;                 // edge k
      tick(2);                           // event evaluates during k+1..k+2
      serial_addr = FR_RB_CHG_CLR; serial_data = 32'h8; serial_strobe = 1'b1;
      sb.push_back('{name:"set_beats_clr", exp:32'h0000_0008});
      tick(1);
      serial_strobe = 1'b0; serial_addr = '0;
      e = sb.pop_front(); total++;
      if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
      sb.push_back('{name:"pin3_clr", exp:32'h0});
      tick(3);
      wr(FR_RB_CHG_CLR, 32'h8);
      e = sb.pop_front(); total++;
      if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
   endtask

   task automatic test_evt_saturate;
      for (int i = 0; i < 70000; i++) begin
         io_0_in[0] = ~io_0_in[0];
         tick(1);
      end
      tick(5);
      sb.push_back('{name:"evt_sat",  exp:32'h0000_FFFF});
      sb.push_back('{name:"snap_sat", exp:{io_1_in, io_0_in}});
      wr(FR_RB_SNAP, 32'h0);
      e = sb.pop_front(); total++;
      if (readback_evt !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_evt, e.exp); end
      e = sb.pop_front(); total++;
      if (readback_snap !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_snap, e.exp); end
      for (int i = 0; i < 5; i++) begin
         io_0_in[0] = ~io_0_in[0];
         tick(5);
      end
      sb.push_back('{name:"evt_five",  exp:32'h0000_0005});
      sb.push_back('{name:"snap_five", exp:{io_1_in, io_0_in}});
      wr(FR_RB_SNAP, 32'h0);
      e = sb.pop_front(); total++;
      if (readback_evt !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_evt, e.exp); end
      e = sb.pop_front(); total++;
      if (readback_snap !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_snap, e.exp); end
   endtask

   task automatic test_reset_mid;
      io_0_in = '0;
      tick(4);
      wr(FR_RB_CHG_CLR, 32'hFFFF_FFFF);
      io_0_in[0] = 1'b1;
      sb.push_back('{name:"pre_rst_irq", exp:32'h1});
      tick(4);
      e = sb.pop_front(); total++;
      if ({31'h0, change_irq} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%h", e.name, change_irq, e.exp); end
      reset = 1'b1; io_0_in = '0;
      sb.push_back('{name:"mid_io",   exp:32'h0});
      sb.push_back('{name:"mid_chg",  exp:32'h0});
      sb.push_back('{name:"mid_snap", exp:32'h0});
      sb.push_back('{name:"mid_evt",  exp:32'h0});
      sb.push_back('{name:"mid_irq",  exp:32'h0});
      tick(1);
      obs = '{readback_io, readback_chg, readback_snap, readback_evt, {31'h0, change_irq}};
      for (int i = 0; i < 5; i++) begin
         e = sb.pop_front(); total++;
         if (obs[i] !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, obs[i], e.exp); end
      end
      // edge lands in the disarm window with its enable already set
      reset = 1'b0;
      serial_addr = FR_RB_EDGE_EN_0; serial_data = 32'h0001_0001; serial_strobe = 1'b1;
      io_0_in[0] = 1'b1;
      tick(1);
      serial_strobe = 1'b0; serial_addr = '0;
      sb.push_back('{name:"disarm_no_flag", exp:32'h0});
      tick(6);
      e = sb.pop_front(); total++;
      if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
      io_0_in[0] = 1'b0;
      sb.push_back('{name:"rearmed_flag",    exp:32'h1});
      sb.push_back('{name:"mask_reset_irq",  exp:32'h0});
      tick(3);
      e = sb.pop_front(); total++;
      if (readback_chg !== e.exp) begin bad++; $display("FAIL %s got=%h want=%h", e.name, readback_chg, e.exp); end
      tick(1);
      e = sb.pop_front(); total++;
      if ({31'h0, change_irq} !== e.exp) begin bad++; $display("FAIL %s got=%b want=%h", e.name, change_irq, e.exp); end
   endtask

   initial begin
      test_reset;
      test_edge_irq;
      test_mask_write;
      test_set_wins;
      test_evt_saturate;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_pins_readback.md
Name: io_pins_readback

Overview:
Host-visible readback and change-capture block for the two 16-bit GPIO banks driven by the OE/output register logic.
- Synchronises pin inputs into the `clock` domain.
- Detects per-pin edges and latches them into sticky flags.
- Raises a maskable interrupt and returns live, sticky and snapshot values on 32-bit readback words.
- Configured over the standard serial register bus (addr/data/strobe).

Parameters:
SYNC_STAGES, 2, synchroniser depth per pin (legal 2..4)
ADDR_EDGE_EN_0, `FR_RB_EDGE_EN_0, mask-write edge enable for bank 0
ADDR_EDGE_EN_1, `FR_RB_EDGE_EN_1, mask-write edge enable for bank 1
ADDR_CHG_CLR, `FR_RB_CHG_CLR, write-1-to-clear sticky flags: [31:16] bank 1, [15:0] bank 0
ADDR_IRQ_MASK, `FR_RB_IRQ_MASK, plain 32-bit write: [31:16] bank 1, [15:0] bank 0
ADDR_SNAP, `FR_RB_SNAP, any write takes a coherent snapshot

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
io_0_in  in  16  raw pad inputs, bank 0 (asynchronous)
io_1_in  in  16  raw pad inputs, bank 1 (asynchronous)
serial_addr  in  7  register address
serial_data  in  32  register data
serial_strobe  in  1  one-cycle write strobe
readback_io  out  32  {io_1_sync, io_0_sync}, live value
readback_chg  out  32  {chg_1, chg_0}, sticky change flags
readback_snap  out  32  {io_1, io_0} captured at the last SNAP write
readback_evt  out  32  {16'h0, event count latched at SNAP}
change_irq  out  1  registered level interrupt

Behaviour:
Reset values:
- All outputs, sync stages, prev, chg, edge_en and irq_mask registers = 0.
- Event counter = 0.
- Arm counter = 0 (detection disarmed).

Synchroniser and arming:
- SYNC_STAGES flops per pin, no reset bypass.
- A pin change sampled at edge k appears on io_x_sync after edge k+SYNC_STAGES-1.
- readback_io is registered one cycle later.
- After reset, detection is disarmed for SYNC_STAGES+1 cycles (arm counter). While disarmed, prev tracks sync and no flags set, so pins already high at reset produce no spurious events.

Edge detect:
- chg_evt_x = (sync_x ^ prev_x) & edge_en_x, evaluated only when armed.
- prev_x <= sync_x every cycle.
- chg_x |= chg_evt_x; flags latch at the edge after sync changes.

Register writes (serial_strobe high):
- EDGE_EN_x: edge_en <= (edge_en & ~d[31:16]) | (d[15:0] & d[31:16]). Upper half is the mask.
- CHG_CLR: clear flags whose bits are 1.
- Same-cycle new event and clear on the same bit: set wins (flag stays 1).

IRQ and counter:
- change_irq <= |({chg_1, chg_0} & irq_mask), i.e. one cycle after the flag.
- Event counter increments by 1 per armed cycle with any nonzero chg_evt (multiple pins in one cycle count once). Saturates at 16'hFFFF, never wraps.

SNAP write:
- readback_snap <= {io_1_sync, io_0_sync} of that cycle.
- readback_evt[15:0] <= counter value including this cycle's increment.
- Counter then restarts at 0, or at 1 if an event occurs the same cycle.

Other rules:
- Unknown addresses are ignored.
- Reset mid-operation: everything returns to reset values next edge and re-enters the disarmed window.

Decomposition:
- Shared register package (fpga_regs_standard include) holds the five FR_RB_* address constants and the field-layout constants BANK1_LSB=16 and EVT_SAT=16'hFFFF.
- One natural sub-module, `pin_edge_capture`, instantiated once per bank. It contains the 16-bit synchroniser, prev, edge_en and sticky flags. The top level holds register decode, IRQ, counter and snapshot.

Test Plan:
1. Reset with io_0_in=16'hFFFF held → readback_io=32'h0000FFFF after 3 cycles; readback_chg stays 0 and change_irq stays 0 for 20 cycles.
2. EDGE_EN_0 write 32'h0001_0001, IRQ_MASK write 32'h1, toggle io_0_in[0] 0→1 at edge k → chg bit0=1 at edge k+2, change_irq=1 at edge k+3. Write CHG_CLR 32'h1 → flag and irq drop.
3. Mask-write EDGE_EN_1 32'h00F0_00A0 from edge_en_1=16'h000F → result 16'h00AF; toggle pin 4 → no flag; toggle pin 5 → flag.
4. CHG_CLR bit 3 in the same cycle as a new edge on pin 3 → flag remains 1.
5. 70000 cycles with pin toggling every cycle (enabled), then SNAP → readback_evt=32'h0000FFFF; next SNAP after 5 events → 5.
6. Assert reset while flags set and irq high → all outputs 0 next cycle; a pin edge inside the disarm window is not flagged.
